lcd_bus_drv: RTL and testbench
==============================

LCD_BUS_DRV -- requirements
Module: lcd_bus_drv

Interface
REQ-001 Parameter TSU, default 2: cycles from bus/RS setup to the rising edge of E; value 0 SHALL behave as 1.
REQ-002 Parameter TEH, default 4: cycles E is held high; value 0 SHALL behave as 1.
REQ-003 Parameter THD, default 2: cycles bus/RS are held after the falling edge of E; value 0 SHALL behave as 1.
REQ-004 Parameter TEXEC, default 8: post-write execution wait for normal commands and data; value 0 SHALL behave as 1.
REQ-005 Parameter TLONG, default 32: post-write execution wait for clear/home commands; value 0 SHALL behave as 1.
REQ-006 Parameter BUS4, default 0: 0 selects an 8-bit LCD bus, 1 selects a 4-bit nibble bus.
REQ-007 Port clk_i, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-008 Port restn_i, input, 1 bit: asynchronous, active-low reset.
REQ-009 Port data_i, input, 9 bits: bit 8 is RS (0 = command, 1 = data) and bits 7:0 are the LCD byte.
REQ-010 Port data_valid_i, input, 1 bit: the upstream word on data_i is valid.
REQ-011 Port ready_o, output, 1 bit: the driver accepts a word this cycle.
REQ-012 Port lcd_rs_o, output, 1 bit: LCD register select.
REQ-013 Port lcd_rw_o, output, 1 bit: LCD read/write, constant 0 (write only).
REQ-014 Port lcd_e_o, output, 1 bit: LCD enable strobe, registered.
REQ-015 Port lcd_db_o, output, 8 bits: LCD data bus; in 4-bit mode, bits 3:0 SHALL be driven 0.

Function
REQ-016 States SHALL be IDLE, SETUP, EHIGH, HOLD and EXEC, with a single cycle counter (20 bits minimum) that clears on every state change.
REQ-017 ready_o SHALL equal (state == IDLE), decoded from registered state, with no combinational path from data_valid_i.
REQ-018 A transfer SHALL occur on a rising edge where ready_o = 1 and data_valid_i = 1: data_i is latched and the next state is SETUP.
REQ-019 data_i and data_valid_i SHALL be ignored outside IDLE; the latched word SHALL be immune to later input changes.
REQ-020 A transferred word equal to 9'h000 SHALL be dropped: no E pulse, state remains IDLE, and ready_o stays 1.
REQ-021 On entry to SETUP, lcd_rs_o SHALL take latched bit 8, and lcd_db_o SHALL take latched[7:0] (8-bit mode) or the current nibble on bits 7:4 (4-bit mode).
REQ-022 SETUP SHALL last TSU cycles with lcd_e_o = 0, then move to EHIGH.
REQ-023 EHIGH SHALL last TEH cycles with lcd_e_o = 1, then move to HOLD.
REQ-024 HOLD SHALL last THD cycles with lcd_e_o = 0 and bus/RS unchanged.
REQ-025 On HOLD exit in 4-bit mode after the high nibble, the state SHALL become SETUP with the low nibble; otherwise it SHALL become EXEC.
REQ-026 EXEC SHALL last TLONG cycles when RS = 0 and byte = 8'h01 or 8'h02, and TEXEC cycles otherwise, then return to IDLE.
REQ-027 lcd_rs_o and lcd_db_o SHALL hold their last values in EXEC and IDLE until the next SETUP entry.
REQ-028 Per-word latency from the transfer edge to ready_o = 1 SHALL be TSU+TEH+THD+EXECWAIT cycles (8-bit mode) or 2*(TSU+TEH+THD)+EXECWAIT cycles (4-bit mode), where EXECWAIT is TEXEC or TLONG per REQ-026.
REQ-029 Exactly one E pulse per byte (8-bit mode) or two per byte (4-bit mode) SHALL be emitted, with no glitches.

Reset
REQ-030 While restn_i = 0, outputs SHALL be: state IDLE, counter 0, ready_o = 1, lcd_e_o = 0, lcd_rs_o = 0, lcd_rw_o = 0, lcd_db_o = 8'h00.
REQ-031 Reset asserted mid-transfer, including during EHIGH, SHALL drop lcd_e_o to 0 asynchronously and abandon the word; no partial nibble SHALL resume after release.
REQ-032 The first transfer SHALL be possible on the first rising edge after restn_i deasserts.

Verification
REQ-033 Defaults, BUS4 = 0, send 9'h141 -> RS = 1, db = 8'h41 from cycle 1; E high in cycles 3-6; ready_o returns to 1 at cycle 16.
REQ-034 Defaults, send 9'h001 -> RS = 0, one E pulse, ready_o returns to 1 at cycle 40; then 9'h003 -> ready_o returns to 1 at cycle 16.
REQ-035 BUS4 = 1, send 9'h1A5 -> db[7:4] = 4'hA then 4'h5 with db[3:0] = 0; two E pulses; ready_o returns to 1 at cycle 24.
REQ-036 Hold data_valid_i = 1 while changing data_i during a transfer -> the value latched at the transfer edge is written, and the next word is accepted only in IDLE.
REQ-037 Send 9'h000 -> no E pulse and ready_o stays 1; assert restn_i = 0 during EHIGH -> lcd_e_o = 0 immediately, then a clean transfer after release.

Source files
------------

// File: rtl/lcd_bus_drv.sv
// Write-only HD44780-style LCD bus driver: latches one 9-bit word (RS + byte),
// sequences setup / E-high / hold timing, then waits out the LCD execution time.
module lcd_bus_drv #(
    parameter int TSU   = 2,
    parameter int TEH   = 4,
    parameter int THD   = 2,
    parameter int TEXEC = 8,
    parameter int TLONG = 32,
    parameter int BUS4  = 0
) (
    input  logic       clk_i,
    input  logic       restn_i,
    input  logic [8:0] data_i,
    input  logic       data_valid_i,
    output logic       ready_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_e_o,
    output logic [7:0] lcd_db_o
);

    localparam int CNT_W = 20;

    // Terminal counts; a zero-cycle phase is stretched to one cycle.
    localparam logic [CNT_W-1:0] TSU_END   = CNT_W'((TSU   <= 0) ? 0 : TSU   - 1);
    localparam logic [CNT_W-1:0] TEH_END   = CNT_W'((TEH   <= 0) ? 0 : TEH   - 1);
    localparam logic [CNT_W-1:0] THD_END   = CNT_W'((THD   <= 0) ? 0 : THD   - 1);
    localparam logic [CNT_W-1:0] TEXEC_END = CNT_W'((TEXEC <= 0) ? 0 : TEXEC - 1);
    localparam logic [CNT_W-1:0] TLONG_END = CNT_W'((TLONG <= 0) ? 0 : TLONG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_HOLD,
        S_EXEC
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [8:0]         word_q, word_d;
    logic               rs_q, rs_d;
    logic [7:0]         db_q, db_d;
    logic               e_q, e_d;
    logic               nib_q, nib_d;
    logic               long_cmd;
    logic [CNT_W-1:0]   exec_end;

    // Clear display (0x01) and return home (0x02) need the long execution wait.
    assign long_cmd = !word_q[8] && ((word_q[7:0] == 8'h01) || (word_q[7:0] == 8'h02));
    assign exec_end = long_cmd ? TLONG_END : TEXEC_END;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        rs_d    = rs_q;
        db_d    = db_q;
        nib_d   = nib_q;
        case (state_q)
            S_IDLE: begin
                if (data_valid_i && (data_i != 9'h000)) begin
                    word_d  = data_i;
                    rs_d    = data_i[8];
                    db_d    = (BUS4 != 0) ? {data_i[7:4], 4'h0} : data_i[7:0];
                    nib_d   = (BUS4 != 0);
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == TSU_END) state_d = S_EHIGH;
            end
            S_EHIGH: begin
                if (cnt_q == TEH_END) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == THD_END) begin
                    if (nib_q) begin
                        db_d    = {word_q[3:0], 4'h0};
                        nib_d   = 1'b0;
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (cnt_q == exec_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + 1'b1;
        // E is registered from the next state so it is a clean flop output.
        e_d   = (state_d == S_EHIGH);
    end

    always_ff @(posedge clk_i or negedge restn_i) begin
        if (!restn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
            rs_q    <= 1'b0;
            db_q    <= '0;
            e_q     <= 1'b0;
            nib_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            nib_q   <= nib_d;
        end
    end

    assign ready_o  = (state_q == S_IDLE);
    assign lcd_rs_o = rs_q;
    assign lcd_rw_o = 1'b0;
    assign lcd_e_o  = e_q;
    assign lcd_db_o = db_q;

endmodule

// File: tb/tb_lcd_bus_drv.sv
// Scoreboard bench for lcd_bus_drv: one 8-bit and one 4-bit instance share clock and reset.
module tb_lcd_bus_drv;

    localparam int TSU = 2;
    localparam int TEH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] data  [2];
    logic       valid [2];
    logic       ready [2];
    logic       rs    [2];
    logic       rw    [2];
    logic       e     [2];
    logic [7:0] db    [2];

    logic [8:0] q0[$];
    logic [8:0] q1[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_bus_drv #(.BUS4(0)) dut8 (
        .clk_i(clk), .restn_i(rst_n), .data_i(data[0]), .data_valid_i(valid[0]),
        .ready_o(ready[0]), .lcd_rs_o(rs[0]), .lcd_rw_o(rw[0]), .lcd_e_o(e[0]),
        .lcd_db_o(db[0])
    );

    lcd_bus_drv #(.BUS4(1)) dut4 (
        .clk_i(clk), .restn_i(rst_n), .data_i(data[1]), .data_valid_i(valid[1]),
        .ready_o(ready[1]), .lcd_rs_o(rs[1]), .lcd_rw_o(rw[1]), .lcd_e_o(e[1]),
        .lcd_db_o(db[1])
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every rising E must match the next expected {RS, bus} entry.
    initial begin
        logic pe0, pe1;
        logic [8:0] exp;
        pe0 = 1'b0;
        pe1 = 1'b0;
        forever begin
            @(negedge clk);
            if (e[0] && !pe0) begin
                if (q0.size() == 0) chk("dut8_unexpected_pulse", {rs[0], db[0]}, 0);
                else begin
                    exp = q0.pop_front();
                    chk("dut8_pulse_rs_db", {rs[0], db[0]}, exp);
                end
                chk("dut8_rw", rw[0], 0);
            end
            if (e[1] && !pe1) begin
                if (q1.size() == 0) chk("dut4_unexpected_pulse", {rs[1], db[1]}, 0);
                else begin
                    exp = q1.pop_front();
                    chk("dut4_pulse_rs_db", {rs[1], db[1]}, exp);
                end
                chk("dut4_rw", rw[1], 0);
            end
            pe0 = e[0];
            pe1 = e[1];
        end
    end

    task automatic send(input int sel, input logic [8:0] w, input int exp_lat,
                        input int exp_pulses, input bit scramble);
        int lat, efirst, ehigh, pulses;
        logic pe;
        logic [8:0] lastv;
        lat = 0;
        while (!ready[sel] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!ready[sel]) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        data[sel]  = w;
        valid[sel] = 1'b1;
        lastv = 9'h000;
        if (w != 9'h000) begin
            if (sel == 0) begin
                q0.push_back(w);
                lastv = w;
            end else begin
                q1.push_back({w[8], w[7:4], 4'h0});
                q1.push_back({w[8], w[3:0], 4'h0});
                lastv = {w[8], w[3:0], 4'h0};
            end
        end
        @(negedge clk);
        lat = 0; efirst = -1; ehigh = 0; pulses = 0; pe = 1'b0;
        while (lat < 300) begin
            if (!scramble) valid[sel] = 1'b0;
            else data[sel] = 9'h100 | 9'($urandom_range(1, 255));
            if (e[sel]) begin
                ehigh++;
                if (efirst < 0) efirst = lat;
                if (!pe) pulses++;
            end
            pe = e[sel];
            if (ready[sel]) break;
            @(negedge clk);
            lat++;
        end
        valid[sel] = 1'b0;
        chk("latency", lat, exp_lat);
        chk("pulse_count", pulses, exp_pulses);
        chk("e_high_cycles", ehigh, exp_pulses * TEH);
        if (exp_pulses > 0) begin
            chk("e_first_cycle", efirst, TSU);
            chk("hold_after_exec", {rs[sel], db[sel]}, lastv);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            data[i]  = 9'h000;
            valid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready", ready[i], 1);
            chk("rst_e", e[i], 0);
            chk("rst_rs", rs[i], 0);
            chk("rst_rw", rw[i], 0);
            chk("rst_db", db[i], 0);
        end
        rst_n = 1'b1;

        send(0, 9'h141, 16, 1, 0);
        send(0, 9'h001, 40, 1, 0);
        send(0, 9'h003, 16, 1, 0);
        send(0, 9'h002, 40, 1, 0);
        send(0, 9'h101, 16, 1, 0);
        send(0, 9'h000, 0, 0, 0);
        send(0, 9'h148, 16, 1, 1);

        send(1, 9'h1A5, 24, 2, 0);
        send(1, 9'h001, 48, 2, 0);

        // Reset in the middle of the first E pulse of a 4-bit transfer.
        data[1]  = 9'h1C3;
        valid[1] = 1'b1;
        q1.push_back({1'b1, 4'hC, 4'h0});
        @(negedge clk);
        valid[1] = 1'b0;
        n = 0;
        while (!e[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("dut4_reached_ehigh", e[1], 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_e", e[1], 0);
        chk("async_rst_ready", ready[1], 1);
        chk("async_rst_rs_db", {rs[1], db[1]}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, 9'h15A, 16, 1, 0);
        repeat (10) @(negedge clk);
        chk("dut4_no_resumed_nibble", q1.size(), 0);
        send(1, 9'h1A5, 24, 2, 0);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
